ifetch: RTL
===========

Name: ifetch

Overview:
- Fetch-side initiator for the synchronous instruction memory (imem) of the 3-stage pipeline.
- Owns the PC and drives the imem address and valid.
- Receives read data one cycle later and presents instruction plus PC to decode.
- Handles decode stall, branch/jump redirect from execute, and illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IMEM_ADDR_W, 14, byte-address width backed by imem (16 KiB); addresses at or above 2**IMEM_ADDR_W are illegal.
- NOP_INST, 32'h0000_0013, value driven on inst when inst_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  32  fetch byte address to imem; combinational
- imem_valid  out  1  imem latches imem_addr[13:2] on posedge when 1; holds the previous address when 0
- imem_rd_data  in  32  imem output; corresponds to the last address accepted with imem_valid=1
- stall  in  1  decode cannot accept; hold the current instruction
- redirect_valid  in  1  execute-stage control transfer
- redirect_pc  in  32  target of redirect
- inst_valid  out  1  inst/inst_pc are a valid correct-path instruction
- inst  out  32  instruction to decode
- inst_pc  out  32  byte PC of inst
- fault_valid  out  1  sticky fetch fault
- fault_pc  out  32  offending address

Behaviour:
- Registers:
  - pc_q: next sequential issue address.
  - resp_valid_q / resp_pc_q: the instruction currently on imem_rd_data.
  - state: RUN or FAULT.
  - fault_pc_q.
- Reset values (asynchronous, rst_n=0):
  - pc_q=RESET_PC, resp_valid_q=0, resp_pc_q=0, state=RUN, fault_pc_q=0.
  - Outputs during reset: inst_valid=0, inst=NOP_INST, inst_pc=0, fault_valid=0, imem_valid=0.
- Issue address: cand = redirect_valid ? redirect_pc : pc_q; imem_addr=cand.
- Legality: legal(cand) = cand[1:0]==2'b00 and cand < 2**IMEM_ADDR_W, compared in 33-bit arithmetic so there is no wrap.
- RUN, each cycle with rst_n=1:
  - Redirect has priority over stall.
  - Issue condition: issue = (redirect_valid | ~stall) & legal(cand); imem_valid=issue.
  - On issue: resp_pc_q<=cand, resp_valid_q<=1, pc_q<=cand+4 (32-bit add).
  - stall=1 and redirect_valid=0: imem_valid=0 and all registers hold. imem holds its output, so inst is stable; no skid buffer is needed.
  - Illegal cand with redirect_valid | ~stall:
    - imem_valid=0, resp_valid_q<=0, fault_pc_q<=cand, state<=FAULT.
    - Applies to a misaligned or out-of-range redirect_pc, and to sequential pc_q running past the top of imem.
- FAULT:
  - fault_valid=1, imem_valid=0 unless a legal redirect arrives, resp_valid_q=0; stall is ignored.
  - Legal redirect_valid: issue as in RUN, state<=RUN, fault clears on the same edge.
  - Illegal redirect_valid: fault_pc_q<=redirect_pc, remain in FAULT.
- Outputs:
  - inst_valid=resp_valid_q.
  - inst = resp_valid_q ? imem_rd_data : NOP_INST.
  - inst_pc=resp_pc_q.
  - fault_pc=fault_pc_q.
- Latency and throughput:
  - Fetch latency is 1 cycle (issue edge to inst_valid).
  - Redirect-to-target latency is 1 cycle; the wrong-path instruction shown in the redirect cycle is replaced with no bubble.
  - Sustained rate is 1 instruction per cycle.
- First cycle after reset release: imem_valid=1, imem_addr=RESET_PC (if stall=0), inst_valid=0.
- Reset mid-stall or mid-fault returns to RUN at RESET_PC; no state survives reset.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined, adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on each cycle with imem_valid=1.
  - perf_stall_cnt increments on each cycle with stall=1 & resp_valid_q=1.
  - Both counters reset to 0 and wrap at 2**32.
- When undefined, the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared define header holds:
  - RESET_PC default.
  - NOP_INST encoding.
  - IMEM_ADDR_W.
  - FSM state encodings: RUN=1'b0, FAULT=1'b1.
- One sub-module, ifetch_addr_chk: combinational legality check (cand, IMEM_ADDR_W) -> legal. It is reused later by the dmem access path.

Test Plan:
- Reset release, stall=0, imem preloaded with mem[0..3]=A,B,C,D:
  - Cycle 1: imem_addr=0x0, inst_valid=0.
  - Cycles 2..5: inst=A,B,C,D with inst_pc=0x0,0x4,0x8,0xC.
- stall=1 for 3 cycles while inst=B at pc 0x4:
  - imem_valid=0; inst=B, inst_pc=0x4 stable for all 3 cycles.
  - C arrives the cycle after stall drops.
- redirect_valid=1, redirect_pc=0x100 together with stall=1:
  - imem_addr=0x100, imem_valid=1.
  - Next cycle inst=mem[0x40], inst_pc=0x100, then 0x104.
- redirect_pc=0x102:
  - imem_valid=0; next cycle inst_valid=0, fault_valid=1, fault_pc=0x102.
  - A later redirect to 0x200 clears the fault and inst_pc=0x200 a cycle after.
- Sequential fetch from 0x3FFC:
  - inst_pc=0x3FFC valid.
  - Next cycle fault_valid=1, fault_pc=0x4000, inst_valid=0.
- rst_n pulsed low while in FAULT:
  - Asynchronous clear: fault_valid=0, inst_valid=0, inst=0x00000013 immediately.
  - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch unit.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
package ifetch_pkg;

    localparam logic [31:0] IFETCH_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] IFETCH_NOP_INST    = 32'h0000_0013;
    localparam int          IFETCH_IMEM_ADDR_W = 14;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_addr_chk.sv
// Combinational legality check for a word access: aligned and below 2**ADDR_W.
// Shared between the fetch path and the data-memory access path.
module ifetch_addr_chk #(
    parameter int ADDR_W = 14
) (
    input  logic [31:0] addr,
    output logic        legal
);

    // 33-bit compare so a 32-bit address space never wraps past the limit.
    logic [32:0] limit;

    assign limit = 33'd1 << ADDR_W;
    assign legal = (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);

endmodule

// File: rtl/ifetch.sv
// Fetch-side initiator for the synchronous imem: owns the PC, handles stall,
// redirect and illegal fetch addresses. Define IFETCH_PERF_EN for perf counters.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IFETCH_RESET_PC,
    parameter int          IMEM_ADDR_W = IFETCH_IMEM_ADDR_W,
    parameter logic [31:0] NOP_INST    = IFETCH_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_valid,
    input  logic [31:0] imem_rd_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault_valid,
    output logic [31:0] fault_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    // Handshake: imem has no back-pressure. imem_valid=1 means imem captures
    // imem_addr on this edge and returns its word on imem_rd_data next cycle;
    // imem_valid=0 leaves imem_rd_data holding the last fetched word.

    ifetch_state_e state_q, state_d;
    logic [31:0]   pc_q;
    logic          resp_valid_q;
    logic [31:0]   resp_pc_q;
    logic [31:0]   fault_pc_q;

    logic [31:0]   cand;
    logic          cand_legal;
    logic          issue;
    logic          fault_set;

    assign cand = redirect_valid ? redirect_pc : pc_q;

    ifetch_addr_chk #(
        .ADDR_W (IMEM_ADDR_W)
    ) u_addr_chk (
        .addr  (cand),
        .legal (cand_legal)
    );

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Redirect wins over stall: a stalled wrong-path instruction is dropped.
                if (redirect_valid || !stall) begin
                    if (cand_legal) begin
                        issue = 1'b1;
                    end else begin
                        fault_set = 1'b1;
                        state_d   = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (redirect_valid) begin
                    if (cand_legal) begin
                        issue   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        fault_set = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'h0;
            fault_pc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                pc_q         <= cand + 32'd4;
                resp_pc_q    <= cand;
                resp_valid_q <= 1'b1;
            end else if (fault_set) begin
                resp_valid_q <= 1'b0;
                fault_pc_q   <= cand;
            end
        end
    end

    // Gated by rst_n so imem sees no request while reset is asserted.
    assign imem_valid  = issue & rst_n;
    assign imem_addr   = cand;
    assign inst_valid  = resp_valid_q;
    assign inst        = resp_valid_q ? imem_rd_data : NOP_INST;
    assign inst_pc     = resp_pc_q;
    assign fault_valid = (state_q == ST_FAULT);
    assign fault_pc    = fault_pc_q;

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (imem_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall && resp_valid_q) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
